// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels, address width
// and small bit helpers used by the target (and reused by the master).
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        I2C_IDLE     = 3'd0,
        I2C_ADDR     = 3'd1,
        I2C_ADDR_ACK = 3'd2,
        I2C_WR_BYTE  = 3'd3,
        I2C_WR_ACK   = 3'd4,
        I2C_RD_BYTE  = 3'd5,
        I2C_RD_ACK   = 3'd6
    } i2c_state_e;

    // Open-drain: a 0 on the bus (data 0 or ACK) means pull low, a 1 means release.
    function automatic logic pull_low(input logic bus_bit);
        return (bus_bit == ACK);
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with SCL edge and START/STOP detection.
// Optional 3-sample majority glitch filter when I2C_TARGET_GLITCH_FILTER_EN is defined.
module i2c_bus_sync (
    input  logic clk_sys,
    input  logic rst,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_level,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
    logic scl_filt_s, sda_filt_s;
    logic scl_prev_r, sda_prev_r;

    // Two-flop synchroniser; resets to the idle-high bus level so no edge is seen after reset.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_pin;
            scl_sync_r <= scl_meta_r;
            sda_meta_r <= sda_pin;
            sda_sync_r <= sda_meta_r;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_hist_r, sda_hist_r;
    logic       scl_filt_r, sda_filt_r;

    // Majority vote over the last three samples rejects single-cycle pulses.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            scl_hist_r <= 3'b111;
            sda_hist_r <= 3'b111;
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
        end else begin
            scl_hist_r <= {scl_hist_r[1:0], scl_sync_r};
            sda_hist_r <= {sda_hist_r[1:0], sda_sync_r};
            scl_filt_r <= i2c_pkg::maj3(scl_hist_r);
            sda_filt_r <= i2c_pkg::maj3(sda_hist_r);
        end
    end

    assign scl_filt_s = scl_filt_r;
    assign sda_filt_s = sda_filt_r;
`else
    assign scl_filt_s = scl_sync_r;
    assign sda_filt_s = sda_sync_r;
`endif

    // One-cycle history of the cleaned signals for edge detection.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_filt_s;
            sda_prev_r <= sda_filt_s;
        end
    end

    assign scl_rise  = scl_filt_s & ~scl_prev_r;
    assign scl_fall  = ~scl_filt_s & scl_prev_r;
    assign sda_level = sda_filt_s;
    assign start_det = scl_filt_s & scl_prev_r & sda_prev_r & ~sda_filt_s;
    assign stop_det  = scl_filt_s & scl_prev_r & ~sda_prev_r & sda_filt_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address match, byte writes to local logic, byte reads from it.
// Glitch filtering in the bus front end is enabled by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addr_match,
    output logic       rw_dir,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE     = I2C_IDLE;
    localparam logic [2:0] ST_ADDR     = I2C_ADDR;
    localparam logic [2:0] ST_ADDR_ACK = I2C_ADDR_ACK;
    localparam logic [2:0] ST_WR_BYTE  = I2C_WR_BYTE;
    localparam logic [2:0] ST_WR_ACK   = I2C_WR_ACK;
    localparam logic [2:0] ST_RD_BYTE  = I2C_RD_BYTE;
    localparam logic [2:0] ST_RD_ACK   = I2C_RD_ACK;

    logic scl_rise_s, scl_fall_s, sda_s, start_s, stop_s;

    i2c_bus_sync u_bus_sync (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .scl_pin   (SCL),
        .sda_pin   (SDA),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .sda_level (sda_s),
        .start_det (start_s),
        .stop_det  (stop_s)
    );

    logic [2:0] state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] byte_s;
    logic       sda_low_r;
    logic       ack_on_r;
    logic       rx_ok_r;
    logic       tx_load_r;
    logic [7:0] rx_data_r;
    logic       rx_valid_r, tx_req_r, addr_match_r, rw_dir_r, busy_r;

    assign byte_s = {shift_r[6:0], sda_s};

    // Protocol FSM; ack_on_r marks that the ninth-clock slot has started (drive begun / ACK seen).
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd7;
            shift_r      <= 8'h00;
            sda_low_r    <= 1'b0;
            ack_on_r     <= 1'b0;
            rx_ok_r      <= 1'b0;
            tx_load_r    <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            tx_req_r     <= 1'b0;
            addr_match_r <= 1'b0;
            rw_dir_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            tx_load_r  <= tx_req_r;
            if (tx_load_r) begin
                shift_r <= tx_data;
            end

            if (start_s) begin
                state_r      <= ST_ADDR;
                bit_cnt_r    <= 3'd7;
                busy_r       <= 1'b1;
                addr_match_r <= 1'b0;
                sda_low_r    <= 1'b0;
                ack_on_r     <= 1'b0;
            end else if (stop_s) begin
                state_r      <= ST_IDLE;
                busy_r       <= 1'b0;
                addr_match_r <= 1'b0;
                sda_low_r    <= 1'b0;
                ack_on_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_low_r <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r <= byte_s;
                            if (bit_cnt_r == 3'd0) begin
                                if (byte_s[7:1] == TARGET_ADDR) begin
                                    state_r      <= ST_ADDR_ACK;
                                    rw_dir_r     <= byte_s[0];
                                    addr_match_r <= 1'b1;
                                    ack_on_r     <= 1'b0;
                                    tx_req_r     <= byte_s[0];
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r - 3'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_on_r) begin
                                sda_low_r <= pull_low(ACK);
                                ack_on_r  <= 1'b1;
                            end else begin
                                ack_on_r  <= 1'b0;
                                bit_cnt_r <= 3'd7;
                                if (rw_dir_r) begin
                                    state_r   <= ST_RD_BYTE;
                                    sda_low_r <= pull_low(shift_r[7]);
                                end else begin
                                    state_r   <= ST_WR_BYTE;
                                    sda_low_r <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise_s) begin
                            shift_r <= byte_s;
                            if (bit_cnt_r == 3'd0) begin
                                state_r  <= ST_WR_ACK;
                                ack_on_r <= 1'b0;
                                rx_ok_r  <= rx_ready;
                                if (rx_ready) begin
                                    rx_data_r  <= byte_s;
                                    rx_valid_r <= 1'b1;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r - 3'd1;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_on_r) begin
                                sda_low_r <= pull_low(rx_ok_r ? ACK : NACK);
                                ack_on_r  <= 1'b1;
                            end else begin
                                sda_low_r <= 1'b0;
                                ack_on_r  <= 1'b0;
                                bit_cnt_r <= 3'd7;
                                state_r   <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        // shift_r[7] is the bit currently on the bus.
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 3'd0) begin
                                sda_low_r <= 1'b0;
                                ack_on_r  <= 1'b0;
                                state_r   <= ST_RD_ACK;
                            end else begin
                                shift_r   <= {shift_r[6:0], 1'b0};
                                sda_low_r <= pull_low(shift_r[6]);
                                bit_cnt_r <= bit_cnt_r - 3'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise_s) begin
                            if (sda_s == NACK) begin
                                state_r   <= ST_IDLE;
                                sda_low_r <= 1'b0;
                            end else begin
                                tx_req_r <= 1'b1;
                                ack_on_r <= 1'b1;
                            end
                        end else if (scl_fall_s && ack_on_r) begin
                            ack_on_r  <= 1'b0;
                            bit_cnt_r <= 3'd7;
                            state_r   <= ST_RD_BYTE;
                            sda_low_r <= pull_low(shift_r[7]);
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        sda_low_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SDA        = sda_low_r ? 1'b0 : 1'bz;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign tx_req     = tx_req_r;
    assign addr_match = addr_match_r;
    assign rw_dir     = rw_dir_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master on a pulled-up open-drain SDA.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       clk_sys = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda_low;
    logic       rx_ready;
    logic [7:0] tx_data;
    wire        sda_bus;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, addr_match, rw_dir, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_valid_cnt = 0;
    int tx_req_cnt   = 0;

    always #5 clk_sys = ~clk_sys;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_target #(.TARGET_ADDR(7'h42)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .SCL        (scl),
        .SDA        (sda_bus),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_req     (tx_req),
        .addr_match (addr_match),
        .rw_dir     (rw_dir),
        .busy       (busy)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk_sys) begin
        if (rx_valid) rx_valid_cnt <= rx_valid_cnt + 1;
        if (tx_req)   tx_req_cnt   <= tx_req_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk_sys);
    endtask

    // One SCL period; SDA set while SCL low, sampled mid-high.
    task automatic bus_bit(input logic drive_bit, output logic seen);
        m_sda_low = (drive_bit == 1'b0);
        wait_q();
        scl = 1'b1;
        wait_q();
        seen = sda_bus;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic [7:0] echo;
        logic       seen;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(b[i], seen);
            echo[i] = seen;
        end
        check_eq("wr_echo", echo, b);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, input logic [7:0] next_tx, output logic [7:0] b);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, seen);
            b[i] = seen;
        end
        tx_data = next_tx;
        bus_bit(m_ack, seen);
        check_eq("rd_ack_slot", seen, m_ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rv0, tq0;

        rst = 1'b1;
        scl = 1'b1;
        m_sda_low = 1'b0;
        rx_ready = 1'b1;
        tx_data = 8'h00;
        repeat (4) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_tx_req", tx_req, 1'b0);
        check_eq("rst_addr_match", addr_match, 1'b0);
        check_eq("rst_rw_dir", rw_dir, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sda", sda_bus, 1'b1);

        // Write 0xA5 to address 0x42
        rv0 = rx_valid_cnt;
        bus_start();
        check_eq("wr_busy", busy, 1'b1);
        write_byte(8'h84, ack);
        check_eq("wr_addr_ack", ack, ACK);
        check_eq("wr_addr_match", addr_match, 1'b1);
        check_eq("wr_rw_dir", rw_dir, 1'b0);
        write_byte(8'hA5, ack);
        check_eq("wr_data_ack", ack, ACK);
        check_eq("wr_rx_valid_cnt", rx_valid_cnt - rv0, 1);
        check_eq("wr_rx_data", rx_data, 8'hA5);
        bus_stop();
        check_eq("wr_busy_stop", busy, 1'b0);
        check_eq("wr_match_stop", addr_match, 1'b0);

        // Read 0x3C then 0xF0, master ACK then NACK
        tq0 = tx_req_cnt;
        tx_data = 8'h3C;
        bus_start();
        write_byte(8'h85, ack);
        check_eq("rd_addr_ack", ack, ACK);
        check_eq("rd_rw_dir", rw_dir, 1'b1);
        read_byte(ACK, 8'hF0, rd);
        check_eq("rd_byte0", rd, 8'h3C);
        read_byte(NACK, 8'h00, rd);
        check_eq("rd_byte1", rd, 8'hF0);
        check_eq("rd_tx_req_cnt", tx_req_cnt - tq0, 2);
        wait_q();
        check_eq("rd_release", sda_bus, 1'b1);
        bus_stop();
        check_eq("rd_busy_stop", busy, 1'b0);

        // Foreign address 0x50
        rv0 = rx_valid_cnt;
        tq0 = tx_req_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("na_addr_nack", ack, NACK);
        check_eq("na_addr_match", addr_match, 1'b0);
        write_byte(8'h11, ack);
        check_eq("na_data_nack", ack, NACK);
        bus_stop();
        check_eq("na_rx_valid_cnt", rx_valid_cnt - rv0, 0);
        check_eq("na_tx_req_cnt", tx_req_cnt - tq0, 0);

        // Write while local logic is not ready
        rv0 = rx_valid_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check_eq("nr_addr_ack", ack, ACK);
        rx_ready = 1'b0;
        write_byte(8'h5A, ack);
        check_eq("nr_data_nack", ack, NACK);
        check_eq("nr_rx_valid_cnt", rx_valid_cnt - rv0, 0);
        check_eq("nr_rx_data_kept", rx_data, 8'hA5);
        bus_stop();
        rx_ready = 1'b1;

        // Write then repeated START into a read
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h77, ack);
        check_eq("rs_data_ack", ack, ACK);
        check_eq("rs_rx_data", rx_data, 8'h77);
        tx_data = 8'h96;
        bus_start();
        check_eq("rs_match_cleared", addr_match, 1'b0);
        check_eq("rs_busy", busy, 1'b1);
        write_byte(8'h85, ack);
        check_eq("rs_addr_ack", ack, ACK);
        check_eq("rs_rw_dir", rw_dir, 1'b1);
        check_eq("rs_addr_match", addr_match, 1'b1);
        read_byte(NACK, 8'h00, rd);
        check_eq("rs_rd_byte", rd, 8'h96);
        bus_stop();

        // Reset while the target pulls SDA low mid-byte
        tx_data = 8'h00;
        bus_start();
        write_byte(8'h85, ack);
        bus_bit(1'b1, ack);
        check_eq("mr_bit7", ack, 1'b0);
        check_eq("mr_driving", sda_bus, 1'b0);
        rst = 1'b1;
        @(negedge clk_sys);
        check_eq("mr_sda_released", sda_bus, 1'b1);
        check_eq("mr_addr_match", addr_match, 1'b0);
        check_eq("mr_rw_dir", rw_dir, 1'b0);
        check_eq("mr_busy", busy, 1'b0);
        check_eq("mr_rx_data", rx_data, 8'h00);
        check_eq("mr_tx_req", tx_req, 1'b0);
        rst = 1'b0;
        bus_stop();
        check_eq("mr_idle_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (subordinate) endpoint that answers the team's I2C master on the same two-wire bus. It oversamples SCL/SDA on a fast system clock and detects START/STOP. It matches a 7-bit address, then either delivers written bytes to local logic or serialises bytes supplied by local logic for master reads. ACK is driven/sampled as 0, NACK as 1; SDA is open-drain (drive 0 or release).

## Interface
- TARGET_ADDR, 7'h42, 7-bit bus address this target answers to.
- clk_sys  input  1  system clock, must be ≥ 8× SCL frequency.
- rst  input  1  synchronous, active-high reset.
- SCL  input  1  bus clock (the target never drives SCL).
- SDA  inout  1  bus data; driven 0 when pulling low, else 1'bz.
- rx_ready  input  1  local logic can accept a written byte; sampled at data-ACK time.
- tx_data  input  8  byte to return on a read; captured one cycle after tx_req.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse, rx_data valid.
- tx_req  output  1  one-cycle pulse requesting the next tx_data.
- addr_match  output  1  high from address ACK until STOP/repeated START.
- rw_dir  output  1  R/W bit of the current transaction (1 = read).
- busy  output  1  high between START and STOP.

## Operation
- Inputs pass through a 2-flop synchroniser; rising/falling edges of SCL derived from the synchronised history.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are legal in any state and override it: START → ADDR (bit counter = 7, busy = 1); STOP → IDLE (busy = 0, addr_match = 0, SDA released).
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
- ADDR: shift SDA in MSB-first on each SCL rising edge; after 8 bits compare [7:1] to TARGET_ADDR. Match → ADDR_ACK, latch rw_dir. Mismatch → IDLE (SDA untouched until next START).
- ADDR_ACK: drive SDA 0 for the ninth clock; addr_match = 1. After ninth falling edge → WR_BYTE (rw = 0) or RD_BYTE (rw = 1). If rw = 1, tx_req pulses on entry to ADDR_ACK.
- WR_BYTE: sample 8 bits on rising edges → WR_ACK. On 8th bit, rx_data updates and rx_valid pulses only if rx_ready = 1.
- WR_ACK: drive 0 if rx_ready was 1, else release (NACK, byte dropped); after the falling edge → WR_BYTE.
- RD_BYTE: shift register loaded from tx_data; bit placed on SDA after each SCL falling edge (drive 0 for a 0 bit, release for a 1 bit); after 8th falling edge release SDA → RD_ACK.
- RD_ACK: sample SDA on rising edge. 0 → tx_req pulse, then RD_BYTE after falling edge. 1 (NACK) → IDLE, released, waiting for STOP.
- Reset mid-transaction: SDA released immediately, all state to IDLE; the bus transaction is abandoned.

## Timing
- Reset values: SDA = z, rx_data = 8'h00, rx_valid = 0, tx_req = 0, addr_match = 0, rw_dir = 0, busy = 0.
- Edge detection latency: 2 clk_sys after a pin change (3 more with the filter enabled).
- SDA drive changes occur one clk_sys after a detected SCL falling edge, never while SCL is high except the START/STOP release.
- tx_data must be stable by the second clk_sys after tx_req; the first bit is driven on the next falling edge.
- Simultaneous START/STOP detection and a data edge in the same cycle: START/STOP wins.

## Configuration
- I2C_TARGET_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchroniser on SCL and SDA, rejecting pulses < 2 clk_sys and adding 3 cycles of latency.
- Undefined: synchronised signals are used directly.

## Structure
- Shared package i2c_pkg: state enum type, ACK = 1'b0 / NACK = 1'b1 constants, address width constant (7); the master reuses the ACK constants.
- One sub-module, i2c_bus_sync: synchroniser, optional filter, SCL edge and START/STOP detection. It feeds the i2c_target FSM.

## Test plan
- Write 0x84 (addr 0x42, W), data 0xA5, rx_ready = 1 → ACKs on both ninth clocks, rx_valid pulses once with rx_data = 0xA5, busy falls at STOP.
- Read 0x85, tx_data = 0x3C then 0xF0, master ACK then NACK → bus carries 0x3C, 0xF0; tx_req pulses twice; the target then releases SDA.
- Address 0x50 → SDA stays released (NACK), addr_match = 0, rx_valid and tx_req never pulse.
- Write with rx_ready = 0 → data ACK slot reads 1, no rx_valid, rx_data keeps its previous value.
- Repeated START after a write byte, then read → the FSM re-enters ADDR, rw_dir = 1, and the read proceeds without an intervening STOP.
- rst asserted mid-byte while the target drives 0 → SDA = z on the next cycle, all outputs return to their reset values.
